// File: rtl/gauss_row_window_if.sv
// gauss_row_window_if
// Groups everything the row window generator exchanges with its neighbours
// apart from clk/rst. The stream feeding the block and the window stream
// leaving it share one bundle so that the pixel source and the window sink
// can be driven from one place.
//   line_width  pixels per row, sampled on a row's first accepted pixel
//   s_valid/s_ready/s_data          incoming raster pixel stream
//   m_valid/m_ready/m_window/m_last outgoing 11-tap windows, [0]=x-5 .. [10]=x+5
//   cfg_err     line_width is illegal while the block waits for a row
// Modports:
//   master  the environment side (drives pixels, line_width and m_ready)
//   slave   the gauss_row_window side
interface gauss_row_window_if #(
  parameter int DATA_W  = 8,
  parameter int TAPS    = 11,
  parameter int WIDTH_W = 11
);
  logic [WIDTH_W-1:0]           line_width;
  logic                         s_valid;
  logic                         s_ready;
  logic [DATA_W-1:0]            s_data;
  logic                         m_valid;
  logic                         m_ready;
  logic [TAPS-1:0][DATA_W-1:0]  m_window;
  logic                         m_last;
  logic                         cfg_err;

  modport master (
    output line_width, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_window, m_last, cfg_err
  );

  modport slave (
    input  line_width, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_window, m_last, cfg_err
  );
endinterface

// File: rtl/gauss_row_window.sv
// gauss_row_window
// Horizontal window generator sitting directly in front of the Gaussian
// dot-product stage. It turns a raster pixel stream into exactly line_width
// 11-tap windows per row (tap 5 is the centre pixel) and handles the row
// edges: by default taps outside the row replicate the first/last pixel.
//
// Optional feature macro: GAUSS_ROW_WINDOW_ZERO_PAD_EN
//   When defined, out-of-row taps are zero instead of replicated. Counts,
//   latency and handshake behaviour are identical in both builds.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   gauss_row_window_if.slave: line_width, s_valid/s_ready/s_data,
//         m_valid/m_ready/m_window/m_last, cfg_err
//
// The output window register is the shift register itself: a shift moves
// every tap one place towards [0] and writes the new value into [TAPS-1].
// Nothing is loaded or shifted unless the output slot is free, so the window,
// m_valid and m_last hold still while the sink stalls.
module gauss_row_window #(
  parameter int DATA_W    = 8,
  parameter int TAPS      = 11,
  parameter int MAX_WIDTH = 1024
) (
  input  logic                clk,
  input  logic                rst,
  gauss_row_window_if.slave   bus
);

  localparam int HALF    = TAPS / 2;
  localparam int WIDTH_W = $clog2(MAX_WIDTH + 1);
  localparam int FCNT_W  = $clog2(HALF + 1);

  localparam logic [WIDTH_W-1:0] MIN_W  = WIDTH_W'(HALF + 1);
  localparam logic [WIDTH_W-1:0] MAX_W  = WIDTH_W'(MAX_WIDTH);
  localparam logic [WIDTH_W-1:0] HALF_W = WIDTH_W'(HALF);
  localparam logic [WIDTH_W-1:0] ONE_W  = WIDTH_W'(1);
  localparam logic [FCNT_W-1:0]  FHALF  = FCNT_W'(HALF);
  localparam logic [FCNT_W-1:0]  FONE   = FCNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [TAPS-1:0][DATA_W-1:0] win_q, win_d;
  logic                        m_valid_q, m_valid_d;
  logic                        m_last_q, m_last_d;
  logic [WIDTH_W-1:0]          width_q, width_d;
  logic [WIDTH_W-1:0]          cnt_q, cnt_d;
  logic [FCNT_W-1:0]           fcnt_q, fcnt_d;

  logic                        slot_free;
  logic                        width_bad;
  logic                        cfg_err;
  logic                        s_ready;
  logic                        accept;
  logic [DATA_W-1:0]           pad_val;
  logic [TAPS-1:0][DATA_W-1:0] load_win;
  logic [TAPS-1:0][DATA_W-1:0] shift_pix;
  logic [TAPS-1:0][DATA_W-1:0] shift_pad;

  // Edge handling: what the first pixel of a row fills the window with, and
  // what gets shifted in after the last pixel of the row.
`ifdef GAUSS_ROW_WINDOW_ZERO_PAD_EN
  assign pad_val  = '0;
  assign load_win = {bus.s_data, {((TAPS - 1) * DATA_W){1'b0}}};
`else
  assign pad_val  = win_q[TAPS-1];
  assign load_win = {TAPS{bus.s_data}};
`endif

  // The two possible shifts of the window register: a new pixel, or the pad
  // value while the right-hand edge is being flushed out.
  assign shift_pix = {bus.s_data, win_q[TAPS-1:1]};
  assign shift_pad = {pad_val, win_q[TAPS-1:1]};

  // Handshake qualification. The output slot is free when it is empty or is
  // being consumed this cycle. A bad line_width only matters while waiting
  // for a row; the block simply refuses pixels until it becomes legal.
  // s_ready and cfg_err are held low for the whole time reset is asserted.
  assign slot_free = !m_valid_q || bus.m_ready;
  assign width_bad = (bus.line_width < MIN_W) || (bus.line_width > MAX_W);
  assign cfg_err   = !rst && (state_q == IDLE) && width_bad;
  assign s_ready   = !rst && slot_free &&
                     (((state_q == IDLE) && !width_bad) ||
                      (state_q == FILL) || (state_q == RUN));
  assign accept    = bus.s_valid && s_ready;

  // Next-state logic. FILL primes the window with the first HALF+1 pixels;
  // the first window (x=0) leaves on the accept of pixel HALF. RUN emits one
  // window per accepted pixel until pixel W-1. FLUSH then emits the last HALF
  // windows by shifting in pad values, the final one flagged with m_last.
  // A row of exactly HALF+1 pixels receives its last pixel while still in
  // FILL, so that case goes straight to FLUSH instead of waiting in RUN.
  // In IDLE the last window of the previous row is retired once consumed.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    width_d   = width_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          width_d   = bus.line_width;
          win_d     = load_win;
          cnt_d     = ONE_W;
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          state_d   = FILL;
        end else if (slot_free) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end

      FILL: begin
        if (accept) begin
          win_d    = shift_pix;
          cnt_d    = cnt_q + ONE_W;
          m_last_d = 1'b0;
          if (cnt_q == HALF_W) begin
            m_valid_d = 1'b1;
            if (width_q == MIN_W) begin
              fcnt_d  = FHALF;
              state_d = FLUSH;
            end else begin
              state_d = RUN;
            end
          end else begin
            m_valid_d = 1'b0;
          end
        end else if (slot_free) begin
          m_valid_d = 1'b0;
        end
      end

      RUN: begin
        if (accept) begin
          win_d     = shift_pix;
          cnt_d     = cnt_q + ONE_W;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          if (cnt_q == (width_q - ONE_W)) begin
            fcnt_d  = FHALF;
            state_d = FLUSH;
          end
        end else if (slot_free) begin
          m_valid_d = 1'b0;
        end
      end

      FLUSH: begin
        if (slot_free) begin
          win_d     = shift_pad;
          m_valid_d = 1'b1;
          m_last_d  = (fcnt_q == FONE);
          fcnt_d    = fcnt_q - FONE;
          if (fcnt_q == FONE) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any partial row and clears
  // the visible window so nothing stale can leave the block afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      width_q   <= '0;
      cnt_q     <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      width_q   <= width_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.cfg_err  = cfg_err;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_window = win_q;
  assign bus.m_last   = m_last_q;

endmodule

// File: tb/tb_gauss_row_window.sv
// tb_gauss_row_window
// Directed bench for gauss_row_window: replicate/zero-pad rows, backpressure,
// minimum row width, illegal width handling and reset in the middle of a row.
// Build with GAUSS_ROW_WINDOW_ZERO_PAD_EN defined to exercise the zero-pad
// variant; the expected windows follow the same macro.
module tb_gauss_row_window;

  localparam int DATA_W    = 8;
  localparam int TAPS      = 11;
  localparam int MAX_WIDTH = 1024;
  localparam int WIDTH_W   = $clog2(MAX_WIDTH + 1);
  localparam int BUDGET    = 400;

  typedef logic [TAPS-1:0][DATA_W-1:0] win_t;
  typedef int tap_arr_t [TAPS];

  logic clk;
  logic rst;

  gauss_row_window_if #(.DATA_W(DATA_W), .TAPS(TAPS), .WIDTH_W(WIDTH_W)) bus ();

  gauss_row_window #(
    .DATA_W   (DATA_W),
    .TAPS     (TAPS),
    .MAX_WIDTH(MAX_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  pix [16];
  win_t        got [32];
  logic        gotLast [32];
  int          nGot;
  int          acceptCyc6;
  int          firstValidCyc;
  logic        rdyPattern [4];

  // One comparison: counts it, and on mismatch counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [95:0] observed,
                             input logic [95:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Window built from a list written [0] .. [TAPS-1].
  function automatic win_t mk(input tap_arr_t v);
    win_t w;
    for (int k = 0; k < TAPS; k++) w[k] = DATA_W'(v[k]);
    return w;
  endfunction

  // Reference window for pixel x of a row held in pix[].
  function automatic win_t expWin(input int x, input int width);
    win_t w;
    for (int k = 0; k < TAPS; k++) begin
      int j;
      j = x - TAPS / 2 + k;
`ifdef GAUSS_ROW_WINDOW_ZERO_PAD_EN
      if (j < 0 || j >= width) w[k] = '0;
      else                     w[k] = pix[j];
`else
      if (j < 0)      j = 0;
      if (j >= width) j = width - 1;
      w[k] = pix[j];
`endif
    end
    return w;
  endfunction

  // Feeds npix pixels of a row and collects windows until width windows have
  // been taken, with optional 1,0,0,1 backpressure. Checks the stall rules on
  // every cycle: s_ready low while stalled and the window held across a stall.
  task automatic applyStimulus(input int width, input int npix, input bit backpressure);
    int   sent;
    int   cyc;
    win_t prevWin;
    logic prevStall;
    sent          = 0;
    cyc           = 0;
    prevWin       = '0;
    prevStall     = 1'b0;
    nGot          = 0;
    acceptCyc6    = -1;
    firstValidCyc = -1;
    bus.line_width = WIDTH_W'(width);
    while ((sent < npix || nGot < width) && cyc < BUDGET) begin
      @(negedge clk);
      bus.m_ready = backpressure ? rdyPattern[cyc % 4] : 1'b1;
      bus.s_valid = (sent < npix);
      bus.s_data  = pix[sent];
      #1;
      if (bus.m_valid && firstValidCyc < 0) firstValidCyc = cyc;
      if (prevStall) begin
        checkOutput("held_window", bus.m_window, prevWin);
        checkOutput("held_valid", bus.m_valid, 1'b1);
      end
      if (bus.m_valid && !bus.m_ready) checkOutput("stall_s_ready", bus.s_ready, 1'b0);
      if (bus.m_valid && bus.m_ready && nGot < 32) begin
        got[nGot]     = bus.m_window;
        gotLast[nGot] = bus.m_last;
        nGot++;
      end
      if (bus.s_valid && bus.s_ready) begin
        sent++;
        if (sent == TAPS / 2 + 1) acceptCyc6 = cyc;
      end
      prevStall = bus.m_valid && !bus.m_ready;
      prevWin   = bus.m_window;
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    checkOutput("row_within_budget", (cyc < BUDGET), 1'b1);
  endtask

  // Compares every collected window and m_last flag of a row with the model.
  task automatic verifyRow(input string tag, input int width);
    checkOutput({tag, "_count"}, nGot, width);
    for (int x = 0; x < width && x < nGot; x++) begin
      checkOutput({tag, "_win"}, got[x], expWin(x, width));
      checkOutput({tag, "_last"}, gotLast[x], (x == width - 1));
    end
  endtask

  win_t t1x0;
  win_t t1x7;
  win_t t4x5;

  initial begin
`ifdef GAUSS_ROW_WINDOW_ZERO_PAD_EN
    t1x0 = mk('{0, 0, 0, 0, 0, 10, 20, 30, 40, 50, 60});
    t1x7 = mk('{30, 40, 50, 60, 70, 80, 0, 0, 0, 0, 0});
    t4x5 = mk('{1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0});
`else
    t1x0 = mk('{10, 10, 10, 10, 10, 10, 20, 30, 40, 50, 60});
    t1x7 = mk('{30, 40, 50, 60, 70, 80, 80, 80, 80, 80, 80});
    t4x5 = mk('{1, 2, 3, 4, 5, 6, 6, 6, 6, 6, 6});
`endif
    rdyPattern[0] = 1'b1;
    rdyPattern[1] = 1'b0;
    rdyPattern[2] = 1'b0;
    rdyPattern[3] = 1'b1;
    for (int i = 0; i < 16; i++) pix[i] = '0;

    // Reset state, with an illegal width and a pixel offered to show the
    // handshake outputs are forced low during reset.
    rst            = 1'b1;
    bus.line_width = WIDTH_W'(5);
    bus.s_valid    = 1'b1;
    bus.s_data     = 8'h55;
    bus.m_ready    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_m_valid", bus.m_valid, 1'b0);
    checkOutput("rst_m_last", bus.m_last, 1'b0);
    checkOutput("rst_m_window", bus.m_window, '0);
    checkOutput("rst_s_ready", bus.s_ready, 1'b0);
    checkOutput("rst_cfg_err", bus.cfg_err, 1'b0);
    bus.s_valid    = 1'b0;
    bus.line_width = WIDTH_W'(8);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle_s_ready", bus.s_ready, 1'b1);

    // T1: W=8, pixels 10..80, sink always ready.
    $display("[TB] T1 W=8 no backpressure");
    for (int i = 0; i < 8; i++) pix[i] = 8'((i + 1) * 10);
    applyStimulus(8, 8, 1'b0);
    verifyRow("t1", 8);
    checkOutput("t1_x0_hand", got[0], t1x0);
    checkOutput("t1_x7_hand", got[7], t1x7);
    checkOutput("t1_latency", firstValidCyc - acceptCyc6, 1);

    // T3: same row with m_ready toggling 1,0,0,1.
    $display("[TB] T3 W=8 backpressure");
    applyStimulus(8, 8, 1'b1);
    verifyRow("t3", 8);
    checkOutput("t3_x0_hand", got[0], t1x0);
    checkOutput("t3_x7_hand", got[7], t1x7);

    // T4: minimum width W=6, pixels 1..6.
    $display("[TB] T4 W=6");
    for (int i = 0; i < 6; i++) pix[i] = 8'(i + 1);
    applyStimulus(6, 6, 1'b0);
    verifyRow("t4", 6);
    checkOutput("t4_x5_hand", got[5], t4x5);
    checkOutput("t4_latency", firstValidCyc - acceptCyc6, 1);

    // T5: illegal widths in IDLE refuse pixels, then a legal width proceeds.
    $display("[TB] T5 cfg_err");
    for (int i = 0; i < 8; i++) pix[i] = 8'((i + 1) * 10);
    @(negedge clk);
    bus.line_width = WIDTH_W'(5);
    bus.s_valid    = 1'b1;
    bus.s_data     = 8'h77;
    #1;
    checkOutput("t5_err_w5", bus.cfg_err, 1'b1);
    checkOutput("t5_s_ready_w5", bus.s_ready, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("t5_err_w5_hold", bus.cfg_err, 1'b1);
    checkOutput("t5_no_output", bus.m_valid, 1'b0);
    bus.line_width = WIDTH_W'(1025);
    @(negedge clk);
    #1;
    checkOutput("t5_err_w1025", bus.cfg_err, 1'b1);
    checkOutput("t5_s_ready_w1025", bus.s_ready, 1'b0);
    bus.s_valid    = 1'b0;
    bus.line_width = WIDTH_W'(8);
    @(negedge clk);
    #1;
    checkOutput("t5_err_w8", bus.cfg_err, 1'b0);
    applyStimulus(8, 8, 1'b0);
    verifyRow("t5", 8);

    // T6: reset after 4 pixels of a W=8 row, then a complete row.
    $display("[TB] T6 reset mid-row");
    bus.line_width = WIDTH_W'(8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = pix[i];
      #1;
      checkOutput("t6_partial_s_ready", bus.s_ready, 1'b1);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_m_valid", bus.m_valid, 1'b0);
    checkOutput("t6_rst_window", bus.m_window, '0);
    checkOutput("t6_rst_s_ready", bus.s_ready, 1'b0);
    @(negedge clk);
    rst            = 1'b0;
    bus.line_width = WIDTH_W'(5);
    #1;
    checkOutput("t6_back_in_idle", bus.cfg_err, 1'b1);
    checkOutput("t6_no_output", bus.m_valid, 1'b0);
    bus.line_width = WIDTH_W'(8);
    applyStimulus(8, 8, 1'b0);
    verifyRow("t6", 8);
    checkOutput("t6_x0_hand", got[0], t1x0);
    checkOutput("t6_x7_hand", got[7], t1x7);

    // The last window must be retired once consumed.
    @(negedge clk);
    #1;
    checkOutput("final_idle_valid", bus.m_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
